// File: rtl/sipo_frame_ctrl_if.sv
// Serial-in / parallel-out frame handshake bundle.
// The slave side is the deserializer and the master side is the serial source plus the word consumer.
interface sipo_frame_ctrl_if #(parameter int WIDTH = 4);
   logic                     sdi;
   logic                     ready;
   logic                     shift_en;
   logic [$clog2(WIDTH)-1:0] bit_cnt;
   logic [WIDTH-1:0]         data;
   logic                     valid;
   logic                     busy;
   logic                     frame_err;
   logic                     overrun;

   modport slave (
      input  sdi, ready,
      output shift_en, bit_cnt, data, valid, busy, frame_err, overrun
   );

   modport master (
      output sdi, ready,
      input  shift_en, bit_cnt, data, valid, busy, frame_err, overrun
   );
endinterface

// File: rtl/sipo_frame_ctrl.sv
// Serial frame deserializer: start bit '1', WIDTH data bits MSB first, stop bit '0'.
// Good words go to a one-deep valid/ready output. An error flags the frame; a word that arrives while the output is full sets the overrun flag.
//   state  | meaning
//   S_IDLE | waiting for a start bit (sdi=1)
//   S_DATA | sampling data bits; bit_cnt is the index of the next bit
//   S_STOP | sampling the stop bit; the word is delivered or discarded here
module sipo_frame_ctrl #(
   parameter int WIDTH = 4
) (
   input logic              clk,
   input logic              reset,
   sipo_frame_ctrl_if.slave bus
);
   localparam int            CW       = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {S_IDLE, S_DATA, S_STOP} state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_sr;
   logic [WIDTH-1:0] r_data;
   logic [CW-1:0]    r_bit_cnt;
   logic             r_valid;
   logic             r_frame_err;
   logic             r_overrun;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_sr        <= '0;
         r_data      <= '0;
         r_bit_cnt   <= '0;
         r_valid     <= 1'b0;
         r_frame_err <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         r_frame_err <= 1'b0;
         if (r_valid && bus.ready)
            r_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.sdi) begin
                  r_state   <= S_DATA;
                  r_bit_cnt <= '0;
               end
            end
            S_DATA: begin
               r_sr <= {r_sr[WIDTH-2:0], bus.sdi};
               if (r_bit_cnt == LAST_BIT) begin
                  r_state   <= S_STOP;
                  r_bit_cnt <= '0;
               end else begin
                  r_bit_cnt <= r_bit_cnt + CW'(1);
               end
            end
            S_STOP: begin
               r_state <= S_IDLE;
               // A load here overrides the consume-clear above, so the output register is refilled in the same cycle it is read.
               if (bus.sdi) begin
                  r_frame_err <= 1'b1;
               end else if (!r_valid || bus.ready) begin
                  r_data  <= r_sr;
                  r_valid <= 1'b1;
               end else begin
                  r_overrun <= 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.shift_en  = (r_state == S_DATA);
   assign bus.busy      = (r_state != S_IDLE);
   assign bus.bit_cnt   = r_bit_cnt;
   assign bus.data      = r_data;
   assign bus.valid     = r_valid;
   assign bus.frame_err = r_frame_err;
   assign bus.overrun   = r_overrun;
endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Directed bench for sipo_frame_ctrl at WIDTH=4: a per-cycle vector table plus hand sequences.
module tb_sipo_frame_ctrl;
   logic clk;
   logic reset;
   int   n_checks;
   int   n_fail;

   sipo_frame_ctrl_if #(.WIDTH(4)) bus ();

   sipo_frame_ctrl #(.WIDTH(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic       sdi;
      logic       rdy;
      logic       sh;
      logic       bs;
      logic [1:0] cnt;
      logic [3:0] dat;
      logic       vl;
      logic       fe;
      logic       ov;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step(input logic r, input logic s, input logic rd);
      @(negedge clk);
      reset     = r;
      bus.sdi   = s;
      bus.ready = rd;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all(input string tag, input vec_t v);
      chk({tag, " shift_en"},  int'(bus.shift_en),  int'(v.sh));
      chk({tag, " busy"},      int'(bus.busy),      int'(v.bs));
      chk({tag, " bit_cnt"},   int'(bus.bit_cnt),   int'(v.cnt));
      chk({tag, " data"},      int'(bus.data),      int'(v.dat));
      chk({tag, " valid"},     int'(bus.valid),     int'(v.vl));
      chk({tag, " frame_err"}, int'(bus.frame_err), int'(v.fe));
      chk({tag, " overrun"},   int'(bus.overrun),   int'(v.ov));
   endtask

   initial begin
      int         n_valid;
      int         first_cyc;
      int         second_cyc;
      logic [3:0] first_dat;
      logic [3:0] second_dat;
      logic       saw_valid;
      logic [11:0] b2b;
      logic [5:0]  clean;

      n_checks  = 0;
      n_fail    = 0;
      reset     = 1'b1;
      bus.sdi   = 1'b1;
      bus.ready = 1'b0;

      //                rst sdi rdy  sh bs cnt  data     vl fe ov
      // reset held with sdi=1
      vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0, 1'b0});
      // ready=1, frame 1011
      vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 4'b0000, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2'd1, 4'b0000, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd2, 4'b0000, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2'd3, 4'b0000, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 4'b0000, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 4'b1011, 1'b1, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 4'b1011, 1'b0, 1'b0, 1'b0});
      // ready=0, frame 1011 then 0110 -> overrun
      vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 4'b1011, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 4'b1011, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 4'b1011, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'd3, 4'b1011, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 4'b1011, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'b1011, 1'b1, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 4'b1011, 1'b1, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 4'b1011, 1'b1, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'd2, 4'b1011, 1'b1, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'd3, 4'b1011, 1'b1, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 4'b1011, 1'b1, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'b1011, 1'b1, 1'b0, 1'b1});
      vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 4'b1011, 1'b0, 1'b0, 1'b1});
      // framing error: start, 0101, stop=1
      vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 4'b1011, 1'b0, 1'b0, 1'b1});
      vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 4'b1011, 1'b0, 1'b0, 1'b1});
      vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'd2, 4'b1011, 1'b0, 1'b0, 1'b1});
      vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd3, 4'b1011, 1'b0, 1'b0, 1'b1});
      vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 4'b1011, 1'b0, 1'b0, 1'b1});
      vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'b1011, 1'b0, 1'b1, 1'b1});
      vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 4'b1011, 1'b0, 1'b0, 1'b1});

      foreach (vecs[i]) begin
         step(vecs[i].rst, vecs[i].sdi, vecs[i].rdy);
         chk_all($sformatf("vec%0d", i), vecs[i]);
      end

      // Abort a frame with reset after two data bits, then receive 1100 cleanly.
      step(1'b1, 1'b0, 1'b1);
      chk("rst overrun cleared", int'(bus.overrun), 0);
      chk("rst data cleared", int'(bus.data), 0);
      step(1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b1, 1'b1);
      chk("abort busy", int'(bus.busy), 0);
      chk("abort bit_cnt", int'(bus.bit_cnt), 0);
      saw_valid = 1'b0;
      clean = 6'b111000;
      for (int k = 5; k >= 0; k--) begin
         step(1'b0, clean[k], 1'b1);
         if (k != 0 && bus.valid) saw_valid = 1'b1;
      end
      chk("abort no stray valid", int'(saw_valid), 0);
      chk("clean valid", int'(bus.valid), 1);
      chk("clean data", int'(bus.data), 4'hC);
      step(1'b0, 1'b0, 1'b1);
      chk("clean consumed", int'(bus.valid), 0);

      // Back-to-back frames 1001 and 0111 at the minimum period.
      b2b = 12'b110010_101110;
      n_valid = 0;
      first_cyc = -1;
      second_cyc = -1;
      first_dat = '0;
      second_dat = '0;
      for (int k = 11; k >= 0; k--) begin
         step(1'b0, b2b[k], 1'b1);
         if (bus.valid) begin
            n_valid++;
            if (first_cyc < 0) begin
               first_cyc = 11 - k;
               first_dat = bus.data;
            end else begin
               second_cyc = 11 - k;
               second_dat = bus.data;
            end
         end
         if (k == 5) chk("b2b second start busy", int'(bus.busy), 1);
      end
      step(1'b0, 1'b0, 1'b1);
      if (bus.valid) n_valid++;
      chk("b2b valid pulses", n_valid, 2);
      chk("b2b first cycle", first_cyc, 5);
      chk("b2b first data", int'(first_dat), 4'h9);
      chk("b2b period", second_cyc - first_cyc, 6);
      chk("b2b second data", int'(second_dat), 4'h7);
      chk("b2b no frame_err", int'(bus.frame_err), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/sipo_frame_ctrl.md
SIPO_FRAME_CTRL -- requirements
Module: sipo_frame_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 4: number of data bits per serial frame; legal range 2..16.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on the rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 SHALL have port sdi  input  1  serial data in, sampled on the rising edge of clk.
REQ-005 SHALL have port ready  input  1  consumer accepts data when valid && ready at a rising edge.
REQ-006 SHALL have port shift_en  output  1  high while in DATA state, marking a data-bit sample cycle.
REQ-007 SHALL have port bit_cnt  output  $clog2(WIDTH)  index of the next data bit to be sampled.
REQ-008 SHALL have port data  output  WIDTH  last good parallel word; the first received bit is the MSB.
REQ-009 SHALL have port valid  output  1  data holds an unconsumed word.
REQ-010 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-011 SHALL have port frame_err  output  1  one-cycle pulse when a frame's stop bit is wrong.
REQ-012 SHALL have port overrun  output  1  sticky flag: a good word was dropped because valid was held.

Function
REQ-013 SHALL implement an FSM with states IDLE, DATA and STOP; shift_en = (state==DATA); busy = (state!=IDLE).
REQ-014 IDLE: sdi=1 at an edge (start bit, not stored) SHALL move to DATA with bit_cnt=0; sdi=0 SHALL keep the FSM in IDLE.
REQ-015 DATA: each edge SHALL shift sr <= {sr[WIDTH-2:0], sdi} and increment bit_cnt.
REQ-016 DATA: at the edge where bit_cnt==WIDTH-1, the FSM SHALL go to STOP and bit_cnt SHALL wrap to 0.
REQ-017 STOP: sdi=0 at the edge is a good frame; sdi=1 is a framing error. Either way, the FSM SHALL return to IDLE.
REQ-018 A framing error SHALL assert frame_err for exactly one cycle; the word SHALL be discarded; data, valid and overrun SHALL be unchanged.
REQ-019 A good frame with valid=0, or with valid=1 && ready=1 at the same edge, SHALL load data<=sr and set valid=1, with no overrun.
REQ-020 A good frame with valid=1 && ready=0 SHALL keep the old data, drop the new word, and set overrun=1.
REQ-021 overrun SHALL be cleared only by reset.
REQ-022 valid && ready at an edge with no load SHALL clear valid; data SHALL hold its value.
REQ-023 Latency: with the start bit sampled at edge E, data bits are sampled at E+1..E+WIDTH and the stop bit at E+WIDTH+1; valid SHALL be visible after edge E+WIDTH+1.
REQ-024 A new start bit SHALL be accepted no earlier than edge E+WIDTH+2; sdi at the STOP edge is never treated as a start bit.
REQ-025 ready SHALL be ignored while valid=0; sdi SHALL be ignored in IDLE except as a start bit.
REQ-026 Back-to-back frames SHALL each be decoded independently; the minimum frame period is WIDTH+2 cycles.

Reset
REQ-027 reset=1 at an edge SHALL force:
- FSM to IDLE;
- sr=0, bit_cnt=0, data=0;
- valid=0, frame_err=0, overrun=0.
REQ-028 reset SHALL override all other inputs, including mid-frame; any partial word SHALL be discarded.
REQ-029 After reset, shift_en=0 and busy=0.

Verification (WIDTH=4)
REQ-030 The bench SHALL cover these scenarios:
- Reset held 2 cycles, sdi=1 -> all outputs 0, FSM remains IDLE.
- ready=1, sdi 1,1,0,1,1,0 on consecutive edges -> shift_en high for 4 cycles; data=4'b1011 and valid=1 for exactly one cycle; frame_err=0.
- ready=0, two good frames (1011, then 0110) -> data stays 4'b1011, valid stays 1, overrun=1; then ready=1 for 1 cycle -> valid=0, overrun still 1.
- Frame 1,0,1,0,1, stop bit=1 -> frame_err pulses one cycle, valid stays 0, data unchanged.
- reset asserted after 2 data bits, then a clean frame with data 1100 -> no valid from the aborted frame; data=4'b1100.
- Back-to-back frames 1001 and 0111, ready=1, period 6 cycles -> two valid pulses 6 cycles apart with the correct data each.
